// File: rtl/mips_mem_sched_pkg.sv
// Shared types and constants for the Harvard MIPS memory scheduler.
//   state_t      : scheduler phase encoding (fetch, data access, commit, halt)
//   RESET_VECTOR : MIPS reset fetch address, used by benches to check fetches
package mips_mem_sched_pkg;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_MEM    = 2'd1,
    S_COMMIT = 2'd2,
    S_HALT   = 2'd3
  } state_t;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

endpackage

// File: rtl/mips_harvard_mem_sched.sv
// Memory scheduler that lets a Harvard MIPS core run from one shared
// Avalon-style port. Every instruction is sequenced as an instruction fetch,
// an optional data access, and a one-cycle clk_enable commit pulse.
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   cpu_active                    : core still running (sampled in commit)
//   clk_enable                    : one-cycle core commit pulse
//   instr_address / instr_readdata: core fetch port (read data registered)
//   data_address/read/write/writedata/readdata : core data port
//   mem_*                         : shared memory bus (waitrequest stalls)
//   commit_count                  : committed instruction count (wraps)
//   proto_err                     : sticky, load and store requested together
//   bus_timeout                   : sticky, waitrequest held TIMEOUT cycles
module mips_harvard_mem_sched
  import mips_mem_sched_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_active,
  output logic        clk_enable,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  input  logic [31:0] data_address,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  output logic [31:0] commit_count,
  output logic        proto_err,
  output logic        bus_timeout
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  state_t        state;
  logic          in_reset;   // high for the cycle(s) following a sampled reset
  logic [CW-1:0] wait_cnt;
  logic          do_read;
  logic          do_write;
  logic          strobe;
  logic          timed_out;

  // Strobes are held low while in_reset so an abandoned access is dropped
  // the cycle after reset is sampled, and the first fetch strobe appears
  // the cycle after reset is released.
  always_comb begin
    do_read  = 1'b0;
    do_write = 1'b0;
    if (!in_reset) begin
      unique case (state)
        S_FETCH: do_read = 1'b1;
        S_MEM: begin
          do_write = data_write;
          do_read  = data_read & ~data_write;  // store wins a conflict
        end
        default: ;
      endcase
    end
  end

  assign strobe        = do_read | do_write;
  assign mem_read      = do_read;
  assign mem_write     = do_write;
  assign mem_address   = (state == S_FETCH) ? instr_address : data_address;
  assign mem_writedata = data_writedata;
  assign clk_enable    = (state == S_COMMIT);

  // This wait cycle would be the TIMEOUT-th consecutive one.
  assign timed_out = (TIMEOUT != 0) && strobe && mem_waitrequest &&
                     (32'(wait_cnt) + 32'd1 == 32'(TIMEOUT));

  always_ff @(posedge clk) begin
    in_reset <= reset;
    if (reset) begin
      state          <= S_FETCH;
      wait_cnt       <= '0;
      instr_readdata <= '0;
      data_readdata  <= '0;
      commit_count   <= '0;
      proto_err      <= 1'b0;
      bus_timeout    <= 1'b0;
    end else begin
      if (strobe && mem_waitrequest) wait_cnt <= wait_cnt + CW'(1);
      else                           wait_cnt <= '0;

      if (timed_out) begin
        bus_timeout <= 1'b1;
        wait_cnt    <= '0;
        state       <= S_HALT;
      end else begin
        unique case (state)
          S_FETCH: begin
            if (!in_reset && !mem_waitrequest) begin
              instr_readdata <= mem_readdata;
              state          <= S_MEM;
            end
          end
          S_MEM: begin
            if (data_read && data_write) proto_err <= 1'b1;
            if (!strobe) begin
              state <= S_COMMIT;
            end else if (!mem_waitrequest) begin
              if (do_read) data_readdata <= mem_readdata;
              state <= S_COMMIT;
            end
          end
          S_COMMIT: begin
            commit_count <= commit_count + 32'd1;
            state        <= cpu_active ? S_FETCH : S_HALT;
          end
          default: state <= S_HALT;
        endcase
      end
    end
  end

endmodule
